// File: rtl/nios_system_mic_pkg.sv
// Shared types and constants for the microphone ring writer: FSM states,
// default geometry, byte-enable patterns and the sample packing helper.
package nios_system_mic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DEPTH  = 128;
    localparam int DEF_OVF_W  = 16;
    localparam int SAMPLE_W   = 16;

    localparam logic [3:0] BE_FULL = 4'b1111;
    localparam logic [3:0] BE_LOW  = 4'b0011;

    function automatic logic [2*SAMPLE_W-1:0] pack_word(input logic [SAMPLE_W-1:0] hi,
                                                         input logic [SAMPLE_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/nios_system_mic_ring_writer_if.sv
// Sample sink and Avalon-MM write-master signals of the ring writer.
// The master modport is the writer's view, slave is the RAM/source side.
interface nios_system_mic_ring_writer_if #(
    parameter int ADDR_W = 7
);
    logic              snk_valid;
    logic [15:0]       snk_data;
    logic              snk_ready;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_writedata;
    logic              avm_clken;

    modport master (
        input  snk_valid, snk_data,
        output snk_ready, avm_address, avm_chipselect, avm_write,
               avm_byteenable, avm_writedata, avm_clken
    );

    modport slave (
        output snk_valid, snk_data,
        input  snk_ready, avm_address, avm_chipselect, avm_write,
               avm_byteenable, avm_writedata, avm_clken
    );
endinterface

// File: rtl/nios_system_sample_packer.sv
// Pairs 16-bit samples into 32-bit words; a flush emits a lone sample
// in the low half-word with only the low byte lanes enabled.
module nios_system_sample_packer
    import nios_system_mic_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  accept,
    input  logic                  flush,
    input  logic [SAMPLE_W-1:0]   data,
    output logic                  pending,
    output logic                  word_valid,
    output logic [2*SAMPLE_W-1:0] word,
    output logic [3:0]            byteenable
);
    logic                pending_q, pending_d;
    logic [SAMPLE_W-1:0] hold_q, hold_d;

    assign pending = pending_q;

    // Pairing decision: complete a word, flush a lone sample, or hold one.
    always_comb begin
        pending_d  = pending_q;
        hold_d     = hold_q;
        word_valid = 1'b0;
        word       = 32'h0000_0000;
        byteenable = 4'b0000;
        if (clear) begin
            pending_d = 1'b0;
        end else if (accept && pending_q) begin
            word_valid = 1'b1;
            word       = pack_word(data, hold_q);
            byteenable = BE_FULL;
            pending_d  = 1'b0;
        end else if (accept && flush) begin
            // A sample landing in the shutdown cycle is written out alone.
            word_valid = 1'b1;
            word       = pack_word(16'h0000, data);
            byteenable = BE_LOW;
            pending_d  = 1'b0;
        end else if (accept) begin
            hold_d    = data;
            pending_d = 1'b1;
        end else if (flush && pending_q) begin
            word_valid = 1'b1;
            word       = pack_word(16'h0000, hold_q);
            byteenable = BE_LOW;
            pending_d  = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Pending-sample storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= 1'b0;
            hold_q    <= 16'h0000;
        end else begin
            pending_q <= pending_d;
            hold_q    <= hold_d;
        end
    end

endmodule

// File: rtl/nios_system_mic_ring_writer.sv
// Streams packed microphone samples into a ping-pong ring in dual-port RAM,
// signalling each completed half and dropping words the CPU has not released.
module nios_system_mic_ring_writer
    import nios_system_mic_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int OVF_W  = DEF_OVF_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    nios_system_mic_ring_writer_if.master bus,
    input  logic                          half_ack,
    input  logic                          full_ack,
    output logic                          half_irq,
    output logic                          full_irq,
    output logic [ADDR_W-1:0]             wr_ptr,
    output logic [OVF_W-1:0]              overflow_cnt
);
    localparam logic [ADDR_W-1:0] LAST_LO = ADDR_W'(DEPTH / 2 - 1);
    localparam logic [ADDR_W-1:0] LAST_HI = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic                own_lo_q, own_lo_d, own_hi_q, own_hi_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [OVF_W-1:0]    ovf_q, ovf_d;
    logic                snk_ready_q, snk_ready_d;
    logic                avm_write_q, avm_write_d;
    logic                avm_cs_q, avm_cs_d;
    logic [ADDR_W-1:0]   avm_address_q, avm_address_d;
    logic [3:0]          avm_be_q, avm_be_d;
    logic [31:0]         avm_data_q, avm_data_d;
    logic                avm_clken_q, avm_clken_d;
    logic                half_irq_q, half_irq_d, full_irq_q, full_irq_d;

    logic                run_s, accept_s, flush_s, clear_s, pending_s;
    logic                word_valid_s, owned_s;
    logic [31:0]         word_s;
    logic [3:0]          be_s;
    logic [ADDR_W-1:0]   cur_ptr_s;

    assign run_s    = (state_q == ST_RUN);
    assign accept_s = run_s & bus.snk_valid;
    assign flush_s  = run_s & ~enable;

    nios_system_sample_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear_s),
        .accept     (accept_s),
        .flush      (flush_s),
        .data       (bus.snk_data),
        .pending    (pending_s),
        .word_valid (word_valid_s),
        .word       (word_s),
        .byteenable (be_s)
    );

    // The pointer advances the cycle after a write; bypass it so a commit
    // right behind a write still targets the following word.
    assign cur_ptr_s = avm_write_q ? (avm_address_q + ADDR_W'(1)) : wr_ptr_q;
    assign owned_s   = cur_ptr_s[ADDR_W-1] ? own_hi_q : own_lo_q;

    // Next-state, commit, ownership and output-register logic.
    always_comb begin
        state_d       = state_q;
        own_lo_d      = own_lo_q;
        own_hi_d      = own_hi_q;
        wr_ptr_d      = cur_ptr_s;
        ovf_d         = ovf_q;
        clear_s       = 1'b0;
        avm_write_d   = 1'b0;
        avm_cs_d      = 1'b0;
        avm_address_d = avm_address_q;
        avm_be_d      = 4'b0000;
        avm_data_d    = 32'h0000_0000;
        avm_clken_d   = 1'b1;
        half_irq_d    = 1'b0;
        full_irq_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d  = ST_RUN;
                    clear_s  = 1'b1;
                    wr_ptr_d = '0;
                    ovf_d    = '0;
                    own_lo_d = 1'b1;
                    own_hi_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = pending_s ? ST_FLUSH : ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (word_valid_s) begin
            if (owned_s) begin
                avm_write_d   = 1'b1;
                avm_cs_d      = 1'b1;
                avm_address_d = cur_ptr_s;
                avm_data_d    = word_s;
                avm_be_d      = be_s;
                if (cur_ptr_s == LAST_LO) begin
                    half_irq_d = 1'b1;
                    own_lo_d   = 1'b0;
                end else begin
                    half_irq_d = 1'b0;
                end
                if (cur_ptr_s == LAST_HI) begin
                    full_irq_d = 1'b1;
                    own_hi_d   = 1'b0;
                end else begin
                    full_irq_d = 1'b0;
                end
            end else begin
                ovf_d = (ovf_q == {OVF_W{1'b1}}) ? ovf_q : (ovf_q + OVF_W'(1));
            end
        end else begin
            avm_write_d = 1'b0;
        end

        // A release from the CPU overrides a clear in the same cycle.
        own_lo_d    = own_lo_d | half_ack;
        own_hi_d    = own_hi_d | full_ack;
        snk_ready_d = (state_d == ST_RUN);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            own_lo_q      <= 1'b1;
            own_hi_q      <= 1'b1;
            wr_ptr_q      <= '0;
            ovf_q         <= '0;
            snk_ready_q   <= 1'b0;
            avm_write_q   <= 1'b0;
            avm_cs_q      <= 1'b0;
            avm_address_q <= '0;
            avm_be_q      <= 4'b0000;
            avm_data_q    <= 32'h0000_0000;
            avm_clken_q   <= 1'b0;
            half_irq_q    <= 1'b0;
            full_irq_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            own_lo_q      <= own_lo_d;
            own_hi_q      <= own_hi_d;
            wr_ptr_q      <= wr_ptr_d;
            ovf_q         <= ovf_d;
            snk_ready_q   <= snk_ready_d;
            avm_write_q   <= avm_write_d;
            avm_cs_q      <= avm_cs_d;
            avm_address_q <= avm_address_d;
            avm_be_q      <= avm_be_d;
            avm_data_q    <= avm_data_d;
            avm_clken_q   <= avm_clken_d;
            half_irq_q    <= half_irq_d;
            full_irq_q    <= full_irq_d;
        end
    end

    assign bus.snk_ready      = snk_ready_q;
    assign bus.avm_write      = avm_write_q;
    assign bus.avm_chipselect = avm_cs_q;
    assign bus.avm_address    = avm_address_q;
    assign bus.avm_byteenable = avm_be_q;
    assign bus.avm_writedata  = avm_data_q;
    assign bus.avm_clken      = avm_clken_q;
    assign half_irq           = half_irq_q;
    assign full_irq           = full_irq_q;
    assign wr_ptr             = wr_ptr_q;
    assign overflow_cnt       = ovf_q;

endmodule

// File: tb/tb_nios_system_mic_ring_writer.sv
// Directed bench for the mic ring writer: a reference model queues expected
// RAM writes as samples are driven, and a monitor pops them as writes appear.
module tb_nios_system_mic_ring_writer;
    import nios_system_mic_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        half_ack = 1'b0;
    logic        full_ack = 1'b0;
    logic        half_irq, full_irq;
    logic [6:0]  wr_ptr;
    logic [15:0] overflow_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hirq_seen = 0;
    int firq_seen = 0;

    typedef struct {
        logic [6:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        hi;
        logic        fi;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    logic [6:0]  m_ptr = 7'd0;
    logic        m_lo = 1'b1;
    logic        m_hi = 1'b1;
    logic [15:0] m_ovf = 16'd0;
    logic        m_pend = 1'b0;
    logic [15:0] m_hold = 16'd0;

    nios_system_mic_ring_writer_if #(.ADDR_W(7)) bus ();

    nios_system_mic_ring_writer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .bus          (bus),
        .half_ack     (half_ack),
        .full_ack     (full_ack),
        .half_irq     (half_irq),
        .full_irq     (full_irq),
        .wr_ptr       (wr_ptr),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 7'd0;
        m_lo   = 1'b1;
        m_hi   = 1'b1;
        m_ovf  = 16'd0;
        m_pend = 1'b0;
    endtask

    // Called at the negedge before the edge that completes the word.
    task automatic model_commit(input logic [31:0] w, input logic [3:0] be);
        exp_t e;
        logic owned;
        owned = m_ptr[6] ? m_hi : m_lo;
        if (owned) begin
            e.a   = m_ptr;
            e.d   = w;
            e.be  = be;
            e.hi  = (m_ptr == 7'd63);
            e.fi  = (m_ptr == 7'd127);
            e.cyc = cyc + 1;
            if (e.hi) m_lo = 1'b0;
            if (e.fi) m_hi = 1'b0;
            sb.push_back(e);
            m_ptr = m_ptr + 7'd1;
        end else if (m_ovf != 16'hFFFF) begin
            m_ovf = m_ovf + 16'd1;
        end
    endtask

    task automatic send(input logic [15:0] d);
        @(negedge clk);
        bus.snk_valid = 1'b1;
        bus.snk_data  = d;
        if (m_pend) begin
            model_commit({d, m_hold}, 4'b1111);
            m_pend = 1'b0;
        end else begin
            m_hold = d;
            m_pend = 1'b1;
        end
    endtask

    task automatic feed(input int n, input int base);
        for (int i = 0; i < n; i++) send(16'(base + i));
        @(negedge clk);
        bus.snk_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (3) @(negedge clk);
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    // Write monitor: every bus write must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus.avm_write) begin
            if (sb.size() == 0) begin
                chk("spurious_wr", 32'(bus.avm_write), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(bus.avm_address), 32'(e.a));
                chk("wr_data", bus.avm_writedata, e.d);
                chk("wr_be", 32'(bus.avm_byteenable), 32'(e.be));
                chk("wr_cs", 32'(bus.avm_chipselect), 32'd1);
                chk("wr_half_irq", 32'(half_irq), 32'(e.hi));
                chk("wr_full_irq", 32'(full_irq), 32'(e.fi));
                chk("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else begin
            chk("irq_no_wr", 32'({half_irq, full_irq}), 32'd0);
        end
        if (half_irq) hirq_seen++;
        if (full_irq) firq_seen++;
    end

    initial begin
        bus.snk_valid = 1'b0;
        bus.snk_data  = 16'h0000;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_write", 32'(bus.avm_write), 32'd0);
        chk("rst_cs", 32'(bus.avm_chipselect), 32'd0);
        chk("rst_be", 32'(bus.avm_byteenable), 32'd0);
        chk("rst_data", bus.avm_writedata, 32'd0);
        chk("rst_addr", 32'(bus.avm_address), 32'd0);
        chk("rst_clken", 32'(bus.avm_clken), 32'd0);
        chk("rst_ready", 32'(bus.snk_ready), 32'd0);
        chk("rst_ptr", 32'(wr_ptr), 32'd0);
        chk("rst_ovf", 32'(overflow_cnt), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("clken_up", 32'(bus.avm_clken), 32'd1);
        chk("idle_ready", 32'(bus.snk_ready), 32'd0);

        // Enable and first two words
        enable = 1'b1;
        model_reset();
        @(negedge clk);
        chk("run_ready", 32'(bus.snk_ready), 32'd1);
        send(16'h0001);
        send(16'h0002);
        send(16'h0003);
        send(16'h0004);
        @(negedge clk);
        bus.snk_valid = 1'b0;
        drain("drain_first");
        chk("ptr_two", 32'(wr_ptr), 32'd2);

        // Fill the lower half
        feed(124, 16'h0100);
        drain("drain_lo");
        chk("ptr_half", 32'(wr_ptr), 32'd64);
        chk("half_irq_cnt", 32'(hirq_seen), 32'd1);
        chk("full_irq_none", 32'(firq_seen), 32'd0);

        // Fill the upper half and wrap
        feed(128, 16'h2000);
        drain("drain_hi");
        chk("ptr_wrap", 32'(wr_ptr), 32'd0);
        chk("full_irq_cnt", 32'(firq_seen), 32'd1);
        chk("half_irq_once", 32'(hirq_seen), 32'd1);

        // Lower half still owned by CPU: word dropped
        feed(2, 16'h5000);
        drain("drain_ovf");
        chk("ovf_one", 32'(overflow_cnt), 32'd1);
        chk("ptr_held", 32'(wr_ptr), 32'd0);
        chk("ovf_model", 32'(overflow_cnt), 32'(m_ovf));

        // Release lower half, next word lands at 0
        @(negedge clk);
        half_ack = 1'b1;
        m_lo = 1'b1;
        @(negedge clk);
        half_ack = 1'b0;
        feed(2, 16'h6000);
        drain("drain_ack");
        chk("ovf_kept", 32'(overflow_cnt), 32'd1);
        chk("ptr_after_ack", 32'(wr_ptr), 32'd1);

        // Stop with nothing pending, restart clears counters
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("stop_ready", 32'(bus.snk_ready), 32'd0);
        enable = 1'b1;
        model_reset();
        @(negedge clk);
        chk("restart_ovf", 32'(overflow_cnt), 32'd0);
        chk("restart_ptr", 32'(wr_ptr), 32'd0);

        // Three samples then stop: low half-word flush
        send(16'h1111);
        send(16'h2222);
        send(16'hABCD);
        @(negedge clk);
        bus.snk_valid = 1'b0;
        enable = 1'b0;
        model_commit({16'h0000, m_hold}, 4'b0011);
        m_pend = 1'b0;
        @(negedge clk);
        chk("flush_state", 32'(dut.state_q), 32'(ST_FLUSH));
        chk("flush_ready", 32'(bus.snk_ready), 32'd0);
        @(negedge clk);
        chk("idle_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("idle_ready2", 32'(bus.snk_ready), 32'd0);
        drain("drain_flush");
        chk("ptr_flush", 32'(wr_ptr), 32'd2);

        // Reset during a write
        enable = 1'b1;
        model_reset();
        @(negedge clk);
        send(16'h0A0A);
        send(16'h0B0B);
        send(16'h0C0C);
        send(16'h0D0D);
        @(negedge clk);
        bus.snk_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        chk("mid_rst_write", 32'(bus.avm_write), 32'd0);
        chk("mid_rst_cs", 32'(bus.avm_chipselect), 32'd0);
        chk("mid_rst_data", bus.avm_writedata, 32'd0);
        chk("mid_rst_addr", 32'(bus.avm_address), 32'd0);
        chk("mid_rst_be", 32'(bus.avm_byteenable), 32'd0);
        chk("mid_rst_clken", 32'(bus.avm_clken), 32'd0);
        chk("mid_rst_ptr", 32'(wr_ptr), 32'd0);
        chk("mid_rst_sb", 32'(sb.size()), 32'd0);
        sb.delete();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rerst_clken", 32'(bus.avm_clken), 32'd1);
        enable = 1'b1;
        @(negedge clk);
        send(16'h7777);
        send(16'h8888);
        @(negedge clk);
        bus.snk_valid = 1'b0;
        drain("drain_rerst");
        chk("rerst_ptr", 32'(wr_ptr), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
